multi_core_reg_bank: RTL
========================

# multi_core_reg_bank

Parametrised memory-mapped configuration and status register bank shared by all processor cores of the dual-core MCU. It replaces the fixed reserved-register window inside data memory. It arbitrates simultaneous core writes round-robin and supports atomic set/clear/toggle bit writes. It merges sticky hardware status flags from the peripherals and drives the flat register image to GPIO, UART, SPI and I2C.

## Interface
Parameters:
- `DATA_WIDTH`, 8, register width in bits
- `REG_AMOUNT`, 11, number of registers
- `CORE_NUM`, 2, number of core access ports
- `ADDR_WIDTH`, `$clog2(REG_AMOUNT)`, per-core address width
- `RESET_VALUE`, all zero, packed `REG_AMOUNT*DATA_WIDTH` reset image; register i occupies bits `[i*DATA_WIDTH +: DATA_WIDTH]`
- `RO_MASK`, all zero, `REG_AMOUNT`-bit mask; bit i set means register i is read-only to cores and writable only by `hw_set`

Ports:
- `clk` in 1: single clock
- `rst` in 1: asynchronous, active-high reset
- `wr_req` in `CORE_NUM`: per-core write request, level
- `wr_addr` in `CORE_NUM*ADDR_WIDTH`: per-core write address
- `wr_data` in `CORE_NUM*DATA_WIDTH`: per-core write data or bit mask
- `wr_mode` in `CORE_NUM*2`: per-core mode; 00 write, 01 set (OR), 10 clear (AND-NOT), 11 toggle (XOR)
- `wr_ack` out `CORE_NUM`: grant/commit strobe
- `wr_err` out `CORE_NUM`: access error strobe, valid with `wr_ack`
- `rd_addr` in `CORE_NUM*ADDR_WIDTH`: per-core read address
- `rd_data` out `CORE_NUM*DATA_WIDTH`: registered read data
- `hw_set` in `REG_AMOUNT*DATA_WIDTH`: per-bit sticky set from peripherals
- `reg_out` out `REG_AMOUNT*DATA_WIDTH`: registered image of all registers

## Operation
- Reset (async on `rst` high): registers load `RESET_VALUE`; RR pointer = 0; `rd_data` = 0. `reg_out` follows registers. `wr_ack`, `wr_err` = 0 while `rst` is high.
- Arbitration: at most one core write commits per cycle. The grant goes to the first requesting core searching from the RR pointer upward, modulo `CORE_NUM`. After a grant the pointer becomes granted+1 mod `CORE_NUM`. With no request the pointer holds.
- Handshake: a core holds `wr_req`/`wr_addr`/`wr_data`/`wr_mode` stable until it sees `wr_ack`. `wr_ack` is combinational, high only for the granted core. The write commits on the rising edge ending that cycle. Dropping `wr_req` before ack is allowed and the request is lost.
- Modify: new = f(old, `wr_data`, `wr_mode`) on the addressed register only.
- Hardware merge, every cycle and every register: next = (core result or old) | `hw_set`. A hardware set beats a same-cycle core clear or toggle of the same bit.
- Invalid write: address ≥ `REG_AMOUNT`, or `RO_MASK` bit set. The write is acked and register contents are unchanged (`hw_set` still applies).
- Read: `rd_data` for core k = register[`rd_addr`k] sampled at the clock edge, i.e. the value before any same-edge write (read-before-write). Out-of-range reads return 0. Reads never stall.

## Timing
- Write latency: ack cycle N, value on `reg_out` and readable via `rd_data` from cycle N+1 (read address presented in N+1, data in N+2).
- Read latency: 1 cycle, fully pipelined per core.
- Worst-case write wait with all cores requesting: `CORE_NUM`-1 cycles.
- Reset asserted mid-handshake: pending writes are discarded, no ack, pointer returns to 0. After release the core must keep its request up.

## Configuration
- `REG_BANK_ACCESS_ERR_EN` defined: `wr_err` pulses high with `wr_ack` for any invalid write (out-of-range or read-only).
- Not defined: invalid writes are acked and silently discarded, and `wr_err` is tied to 0.

## Test plan
- Reset: `RESET_VALUE` reg4=0x23, reg10=0xF8; assert `rst` mid-cycle → `reg_out` shows 0x23/0xF8 immediately, `rd_data`=0, no acks.
- Contention: both cores `wr_req` every cycle, core0 writes reg0=0x11, core1 writes reg1=0x22. Required: acks in order core0, core1 (pointer starts 0); reg0=0x11, reg1=0x22. With continuous requests, acks alternate 0,1,0,1.
- Atomic modes: reg6=0x0F. Core0 set 0x30 → 0x3F. Clear 0x05 → 0x3A. Toggle 0xFF → 0xC5. Each ack is one cycle and each value is visible on `reg_out` the next cycle.
- Hardware priority: reg2=0x81. In the same cycle core1 clears 0x81 and `hw_set` reg2=0x01 → reg2=0x01.
- Read-before-write: reg0=0x00, core0 writes 0x5A while core1 `rd_addr`=0 in the same cycle → core1 `rd_data`=0x00. Reading again the next cycle returns 0x5A.
- Error path: `RO_MASK` bit3 set, core0 writes reg3=0xFF, and separately writes address 12 with `REG_AMOUNT`=11. Required: both acked and both registers unchanged. With the macro, `wr_err`=1 on each ack; without it, `wr_err`=0.

Source files
------------

// File: rtl/multi_core_reg_bank_if.sv
// Core-side bus of multi_core_reg_bank: per-core write handshake and read port.
// Every per-core field is packed flat, with core k occupying slice k.
interface multi_core_reg_bank_if #(
  parameter int CORE_NUM   = 2,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic [CORE_NUM-1:0]            wr_req;
  logic [CORE_NUM*ADDR_WIDTH-1:0] wr_addr;
  logic [CORE_NUM*DATA_WIDTH-1:0] wr_data;
  logic [CORE_NUM*2-1:0]          wr_mode;
  logic [CORE_NUM-1:0]            wr_ack;
  logic [CORE_NUM-1:0]            wr_err;
  logic [CORE_NUM*ADDR_WIDTH-1:0] rd_addr;
  logic [CORE_NUM*DATA_WIDTH-1:0] rd_data;

  modport master (
    output wr_req, wr_addr, wr_data, wr_mode, rd_addr,
    input  wr_ack, wr_err, rd_data
  );

  modport slave (
    input  wr_req, wr_addr, wr_data, wr_mode, rd_addr,
    output wr_ack, wr_err, rd_data
  );
endinterface

// File: rtl/multi_core_reg_bank.sv
// Shared config/status register bank: round-robin core writes with set/clear/toggle,
// sticky hw_set merge, registered reads. Define REG_BANK_ACCESS_ERR_EN to drive wr_err.
module multi_core_reg_bank #(
  parameter int DATA_WIDTH = 8,
  parameter int REG_AMOUNT = 11,
  parameter int CORE_NUM   = 2,
  parameter int ADDR_WIDTH = $clog2(REG_AMOUNT),
  parameter logic [REG_AMOUNT*DATA_WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [REG_AMOUNT-1:0]            RO_MASK     = '0
) (
  input  logic                             clk,
  input  logic                             rst,
  multi_core_reg_bank_if.slave             bus,
  input  logic [REG_AMOUNT*DATA_WIDTH-1:0] hw_set,
  output logic [REG_AMOUNT*DATA_WIDTH-1:0] reg_out
);
  localparam int PTR_W = (CORE_NUM > 1) ? $clog2(CORE_NUM) : 1;

  typedef enum logic [1:0] {
    MODE_WR  = 2'b00,
    MODE_SET = 2'b01,
    MODE_CLR = 2'b10,
    MODE_TGL = 2'b11
  } mode_e;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [1:0]            mode;
  } wr_cmd_t;

  logic [REG_AMOUNT-1:0][DATA_WIDTH-1:0] regs, regs_nxt;
  logic [CORE_NUM-1:0][DATA_WIDTH-1:0]   rd_q, rd_nxt;
  logic [PTR_W-1:0]                      ptr, ptr_nxt;
  logic [CORE_NUM-1:0]                   gnt;
  logic                                  found;
  wr_cmd_t                               sel;
  logic [REG_AMOUNT-1:0]                 hit;
  logic [DATA_WIDTH-1:0]                 old_val, mod_val;

  // Round-robin: scan offsets from ptr, first requesting core wins.
  always_comb begin
    gnt     = '0;
    found   = 1'b0;
    ptr_nxt = ptr;
    sel     = '0;
    for (int i = 0; i < CORE_NUM; i++) begin
      for (int j = 0; j < CORE_NUM; j++) begin
        if (!found && bus.wr_req[j] && (j == (int'(ptr) + i) % CORE_NUM)) begin
          found    = 1'b1;
          gnt[j]   = 1'b1;
          ptr_nxt  = PTR_W'((j + 1) % CORE_NUM);
          sel.addr = bus.wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
          sel.data = bus.wr_data[j*DATA_WIDTH +: DATA_WIDTH];
          sel.mode = bus.wr_mode[j*2 +: 2];
        end
      end
    end
  end

  // Decode the granted address; read-only and out-of-range targets never hit.
  always_comb begin
    old_val = '0;
    hit     = '0;
    for (int r = 0; r < REG_AMOUNT; r++) begin
      if (sel.addr == ADDR_WIDTH'(r)) begin
        old_val = regs[r];
        hit[r]  = found && !RO_MASK[r];
      end
    end
    mod_val = sel.data;
    case (mode_e'(sel.mode))
      MODE_SET: mod_val = old_val | sel.data;
      MODE_CLR: mod_val = old_val & ~sel.data;
      MODE_TGL: mod_val = old_val ^ sel.data;
      default:  mod_val = sel.data;
    endcase
  end

  // hw_set is OR-ed last so a peripheral flag beats a same-cycle clear/toggle.
  always_comb begin
    regs_nxt = regs;
    for (int r = 0; r < REG_AMOUNT; r++)
      regs_nxt[r] = (hit[r] ? mod_val : regs[r]) | hw_set[r*DATA_WIDTH +: DATA_WIDTH];
  end

  // Reads sample the pre-write image; unmapped addresses read as zero.
  always_comb begin
    rd_nxt = '0;
    for (int k = 0; k < CORE_NUM; k++)
      for (int r = 0; r < REG_AMOUNT; r++)
        if (bus.rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(r))
          rd_nxt[k] = regs[r];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs <= RESET_VALUE;
      ptr  <= '0;
      rd_q <= '0;
    end else begin
      regs <= regs_nxt;
      ptr  <= ptr_nxt;
      rd_q <= rd_nxt;
    end
  end

  assign reg_out     = regs;
  assign bus.rd_data = rd_q;
  assign bus.wr_ack  = rst ? '0 : gnt;

`ifdef REG_BANK_ACCESS_ERR_EN
  assign bus.wr_err = (rst || !found || (|hit)) ? '0 : gnt;
`else
  assign bus.wr_err = '0;
`endif

endmodule
